// File: rtl/pkg_en.sv
// Shared token definitions for the ALU pipeline: forward/backward token
// structs and the operand-pair stage state encoding.
package pkg_en;

  localparam int WIDTH_DATA = 32;

  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  c;
    logic                  r;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic v;
    logic n;
    logic t;
    logic c;
  } BTk_t;

  typedef enum logic [1:0] {
    PAIR_RUN,
    PAIR_FLUSH,
    PAIR_DONE
  } pair_fsm_t;

endpackage

// File: rtl/alu_operand_pair_tk_fifo.sv
// Small token FIFO: registered storage, combinational head read.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module tk_fifo
  import pkg_en::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = FTk_t,
  localparam int WIDTH_DEPTH = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  T                     pushData,
  input  logic                 pop,
  output T                     head,
  output logic [WIDTH_DEPTH:0] count,
  output logic                 full,
  output logic                 empty
);

  T                       mem [DEPTH];
  logic [WIDTH_DEPTH-1:0] wrPtr;
  logic [WIDTH_DEPTH-1:0] rdPtr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head  = mem[rdPtr];
    full  = (count == (WIDTH_DEPTH+1)'(DEPTH));
    empty = (count == '0);
  end

endmodule

// File: rtl/alu_operand_pair.sv
// Operand staging ahead of the add/sub ALU: buffers A and B token streams,
// issues them as a pair, and runs the term/flush handshake back upstream.
module alu_operand_pair
  import pkg_en::*;
#(
  parameter int DEPTH       = 4,
  parameter int WIDTH_DEPTH = $clog2(DEPTH)
) (
  input  logic clock,
  input  logic reset,
  input  logic I_En,
  input  FTk_t I_FTkA,
  output BTk_t O_BTkA,
  input  FTk_t I_FTkB,
  output BTk_t O_BTkB,
  output FTk_t O_OperandA,
  output FTk_t O_OperandB,
  input  BTk_t I_BTk,
  output logic O_Empty
);

  // Handshake: a token is taken when I_FTkX.v=1 and the FIFO has room; the
  // producer must stop within one cycle of O_BTkX.n rising. A pair is consumed
  // by the ALU in every cycle O_OperandA.v=O_OperandB.v=1 (already qualified by I_BTk.n).

  localparam logic [WIDTH_DEPTH:0] NEAR_FULL = (WIDTH_DEPTH+1)'(DEPTH - 1);

  pair_fsm_t              state;
  FTk_t                   headA, headB;
  logic [WIDTH_DEPTH:0]   countA, countB, nextCntA, nextCntB;
  logic                   fullA, fullB, emptyA, emptyB;
  logic                   pushA, pushB, popA, popB;
  logic                   fire, flushing;
  logic                   nackA, nackB;

  always_comb begin
    flushing = (state == PAIR_FLUSH);
    fire     = I_En & headA.v & headB.v & ~emptyA & ~emptyB & ~I_BTk.n
             & (state == PAIR_RUN);
    popA     = fire | (flushing & ~emptyA);
    popB     = fire | (flushing & ~emptyB);
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    pushA    = I_FTkA.v & ~flushing & (~fullA | popA);
    pushB    = I_FTkB.v & ~flushing & (~fullB | popB);
    nextCntA = countA + (WIDTH_DEPTH+1)'(pushA) - (WIDTH_DEPTH+1)'(popA);
    nextCntB = countB + (WIDTH_DEPTH+1)'(pushB) - (WIDTH_DEPTH+1)'(popB);
  end

  tk_fifo #(.DEPTH(DEPTH), .T(FTk_t)) u_fifoA (
    .clock(clock), .reset(reset), .push(pushA), .pushData(I_FTkA), .pop(popA),
    .head(headA), .count(countA), .full(fullA), .empty(emptyA)
  );

  tk_fifo #(.DEPTH(DEPTH), .T(FTk_t)) u_fifoB (
    .clock(clock), .reset(reset), .push(pushB), .pushData(I_FTkB), .pop(popB),
    .head(headB), .count(countB), .full(fullB), .empty(emptyB)
  );

  // Nack is loaded from the next count so it reflects the current occupancy
  // one entry before full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= PAIR_RUN;
      nackA <= 1'b0;
      nackB <= 1'b0;
    end else begin
      nackA <= (nextCntA >= NEAR_FULL);
      nackB <= (nextCntB >= NEAR_FULL);
      case (state)
        PAIR_RUN:   if (I_BTk.t) state <= PAIR_FLUSH;
        PAIR_FLUSH: if (nextCntA == '0 && nextCntB == '0) state <= PAIR_DONE;
        PAIR_DONE:  state <= PAIR_RUN;
        default:    state <= PAIR_RUN;
      endcase
    end
  end

  always_comb begin
    O_OperandA   = headA;
    O_OperandA.v = fire;
    O_OperandB   = headB;
    O_OperandB.v = fire;

    O_BTkA   = '0;
    O_BTkA.v = I_BTk.v;
    O_BTkA.c = I_BTk.c;
    O_BTkA.n = nackA | flushing;
    O_BTkA.t = (state == PAIR_DONE);

    O_BTkB   = '0;
    O_BTkB.v = I_BTk.v;
    O_BTkB.c = I_BTk.c;
    O_BTkB.n = nackB | flushing;
    O_BTkB.t = (state == PAIR_DONE);

    O_Empty = emptyA & emptyB & (state == PAIR_RUN);
  end

endmodule
